// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: single-access load/store sequencer between the control FSM
// and the memory port. It checks width legality and alignment, steers store
// data and byte enables onto the bus lanes, and extends load data on return.
// A bus timeout guarantees every accepted request produces one response.

module lsu_mem_ctrl #(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [2:0]        req_funct3,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              resp_valid,
    output logic [XLEN-1:0]   resp_rdata,
    output logic [1:0]        resp_err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [XLEN-1:0]   mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [XLEN/8-1:0] mem_byte_en,
    input  logic [XLEN-1:0]   mem_rdata,
    input  logic              mem_resp
);

    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);
    localparam int CW   = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_ALIGN   = 2'b01;
    localparam logic [1:0] ERR_WIDTH   = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // Width code is illegal if reserved, wider than the datapath, or an
    // unsigned variant used for a store.
    function automatic logic width_illegal(input logic wr, input logic [2:0] f3);
        logic r;
        if (f3 == 3'b111) begin
            r = 1'b1;
        end else if (wr && f3[2]) begin
            r = 1'b1;
        end else if ((XLEN == 32) && ((f3 == 3'b011) || (f3 == 3'b110))) begin
            r = 1'b1;
        end else begin
            r = 1'b0;
        end
        return r;
    endfunction

    // Natural alignment: low address bits must be zero for the access size.
    function automatic logic addr_misaligned(input logic [1:0] sz, input logic [2:0] a);
        logic r;
        case (sz)
            2'b00:   r = 1'b0;
            2'b01:   r = a[0];
            2'b10:   r = |a[1:0];
            default: r = |a[2:0];
        endcase
        return r;
    endfunction

    // Number of bytes touched by an access of size code sz.
    function automatic int size_bytes(input logic [1:0] sz);
        int nb;
        case (sz)
            2'b00:   nb = 1;
            2'b01:   nb = 2;
            2'b10:   nb = 4;
            default: nb = 8;
        endcase
        return nb;
    endfunction

    // Unshifted byte-enable mask for an access size (lane 0 upward).
    function automatic logic [NB-1:0] base_mask(input logic [1:0] sz);
        logic [NB-1:0] m;
        int            nb;
        nb = size_bytes(sz);
        for (int i = 0; i < NB; i++) begin
            m[i] = (i < nb);
        end
        return m;
    endfunction

    // Expand a byte-enable mask into a bit mask.
    function automatic logic [XLEN-1:0] expand_mask(input logic [NB-1:0] be);
        logic [XLEN-1:0] m;
        for (int i = 0; i < NB; i++) begin
            m[8*i +: 8] = {8{be[i]}};
        end
        return m;
    endfunction

    // Sign- or zero-extend right-justified load data from the access width.
    function automatic logic [XLEN-1:0] load_ext(input logic [2:0] f3, input logic [XLEN-1:0] s);
        logic [XLEN-1:0] r;
        logic            fill;
        int              nb;
        nb = size_bytes(f3[1:0]);
        case (f3[1:0])
            2'b00:   fill = s[7];
            2'b01:   fill = s[15];
            2'b10:   fill = s[31];
            default: fill = s[XLEN-1];
        endcase
        fill = fill & ~f3[2];
        for (int i = 0; i < NB; i++) begin
            r[8*i +: 8] = (i < nb) ? s[8*i +: 8] : {8{fill}};
        end
        return r;
    endfunction

    state_t            state_r;
    logic              req_ready_r;
    logic              write_r;
    logic [2:0]        f3_r;
    logic [OFFW-1:0]   off_r;
    logic [CW-1:0]     cnt_r;
    logic              mem_read_r;
    logic              mem_write_r;
    logic [XLEN-1:0]   mem_addr_r;
    logic [XLEN-1:0]   mem_wdata_r;
    logic [NB-1:0]     mem_be_r;
    logic              resp_valid_r;
    logic [XLEN-1:0]   resp_rdata_r;
    logic [1:0]        resp_err_r;

    logic [OFFW-1:0]   req_off_s;
    logic              req_illegal_s;
    logic              req_misal_s;
    logic [NB-1:0]     req_be_s;
    logic [XLEN-1:0]   req_wdata_s;
    logic [XLEN-1:0]   req_maddr_s;
    logic [XLEN-1:0]   rd_shift_s;
    logic [XLEN-1:0]   ld_data_s;

    // Request decode and lane steering, plus load-return alignment.
    always_comb begin
        req_off_s     = req_addr[OFFW-1:0];
        req_illegal_s = width_illegal(req_write, req_funct3);
        req_misal_s   = addr_misaligned(req_funct3[1:0], req_addr[2:0]);
        req_be_s      = base_mask(req_funct3[1:0]) << req_off_s;
        req_maddr_s   = {req_addr[XLEN-1:OFFW], {OFFW{1'b0}}};
        if (req_write) begin
            req_wdata_s = (req_wdata << {req_off_s, 3'b000}) & expand_mask(req_be_s);
        end else begin
            req_wdata_s = {XLEN{1'b0}};
        end
        rd_shift_s = mem_rdata >> {off_r, 3'b000};
        if (write_r) begin
            ld_data_s = {XLEN{1'b0}};
        end else begin
            ld_data_s = load_ext(f3_r, rd_shift_s);
        end
    end

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            req_ready_r  <= 1'b1;
            write_r      <= 1'b0;
            f3_r         <= 3'b000;
            off_r        <= {OFFW{1'b0}};
            cnt_r        <= {CW{1'b0}};
            mem_read_r   <= 1'b0;
            mem_write_r  <= 1'b0;
            mem_addr_r   <= {XLEN{1'b0}};
            mem_wdata_r  <= {XLEN{1'b0}};
            mem_be_r     <= {NB{1'b0}};
            resp_valid_r <= 1'b0;
            resp_rdata_r <= {XLEN{1'b0}};
            resp_err_r   <= ERR_OK;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_valid) begin
                        write_r     <= req_write;
                        f3_r        <= req_funct3;
                        off_r       <= req_off_s;
                        req_ready_r <= 1'b0;
                        if (req_illegal_s) begin
                            state_r      <= ST_RESP;
                            resp_valid_r <= 1'b1;
                            resp_err_r   <= ERR_WIDTH;
                        end else if (req_misal_s) begin
                            state_r      <= ST_RESP;
                            resp_valid_r <= 1'b1;
                            resp_err_r   <= ERR_ALIGN;
                        end else begin
                            state_r     <= ST_ISSUE;
                            mem_read_r  <= ~req_write;
                            mem_write_r <= req_write;
                            mem_addr_r  <= req_maddr_s;
                            mem_wdata_r <= req_wdata_s;
                            mem_be_r    <= req_be_s;
                        end
                    end
                end
                ST_ISSUE: begin
                    mem_read_r  <= 1'b0;
                    mem_write_r <= 1'b0;
                    cnt_r       <= {CW{1'b0}};
                    if (mem_resp) begin
                        state_r      <= ST_RESP;
                        resp_valid_r <= 1'b1;
                        resp_err_r   <= ERR_OK;
                        resp_rdata_r <= ld_data_s;
                        mem_addr_r   <= {XLEN{1'b0}};
                        mem_wdata_r  <= {XLEN{1'b0}};
                        mem_be_r     <= {NB{1'b0}};
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (mem_resp) begin
                        state_r      <= ST_RESP;
                        resp_valid_r <= 1'b1;
                        resp_err_r   <= ERR_OK;
                        resp_rdata_r <= ld_data_s;
                        mem_addr_r   <= {XLEN{1'b0}};
                        mem_wdata_r  <= {XLEN{1'b0}};
                        mem_be_r     <= {NB{1'b0}};
                    end else if (cnt_r == CW'(TIMEOUT_CYCLES - 1)) begin
                        // This is the last permitted wait cycle.
                        state_r      <= ST_RESP;
                        resp_valid_r <= 1'b1;
                        resp_err_r   <= ERR_TIMEOUT;
                        resp_rdata_r <= {XLEN{1'b0}};
                        mem_addr_r   <= {XLEN{1'b0}};
                        mem_wdata_r  <= {XLEN{1'b0}};
                        mem_be_r     <= {NB{1'b0}};
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                ST_RESP: begin
                    state_r      <= ST_IDLE;
                    req_ready_r  <= 1'b1;
                    resp_valid_r <= 1'b0;
                    resp_rdata_r <= {XLEN{1'b0}};
                    resp_err_r   <= ERR_OK;
                end
                default: begin
                    state_r      <= ST_IDLE;
                    req_ready_r  <= 1'b1;
                    mem_read_r   <= 1'b0;
                    mem_write_r  <= 1'b0;
                    mem_addr_r   <= {XLEN{1'b0}};
                    mem_wdata_r  <= {XLEN{1'b0}};
                    mem_be_r     <= {NB{1'b0}};
                    resp_valid_r <= 1'b0;
                    resp_rdata_r <= {XLEN{1'b0}};
                    resp_err_r   <= ERR_OK;
                end
            endcase
        end
    end

    assign req_ready   = req_ready_r;
    assign resp_valid  = resp_valid_r;
    assign resp_rdata  = resp_rdata_r;
    assign resp_err    = resp_err_r;
    assign mem_read    = mem_read_r;
    assign mem_write   = mem_write_r;
    assign mem_addr    = mem_addr_r;
    assign mem_wdata   = mem_wdata_r;
    assign mem_byte_en = mem_be_r;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: one XLEN=32 and one XLEN=64 instance (both with a
// short timeout) share a request bus; cur_sel routes stimulus and observation.
module tb_lsu_mem_ctrl;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [63:0] req_addr = 64'h0;
    logic [63:0] req_wdata = 64'h0;
    logic [63:0] mem_rdata = 64'h0;
    logic        mem_resp = 1'b0;
    logic        cur_sel = 1'b0;

    logic        a_ready, a_rv, a_mr, a_mw;
    logic [31:0] a_rdata, a_maddr, a_mwdata;
    logic [1:0]  a_err;
    logic [3:0]  a_be;
    logic        b_ready, b_rv, b_mr, b_mw;
    logic [63:0] b_rdata, b_maddr, b_mwdata;
    logic [1:0]  b_err;
    logic [7:0]  b_be;

    logic        o_ready, o_rv, o_mr, o_mw;
    logic [63:0] o_rdata, o_maddr, o_mwdata;
    logic [1:0]  o_err;
    logic [7:0]  o_be;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    lsu_mem_ctrl #(.XLEN(32), .TIMEOUT_CYCLES(TO)) dut32 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid & ~cur_sel), .req_ready(a_ready),
        .req_write(req_write), .req_funct3(req_funct3),
        .req_addr(req_addr[31:0]), .req_wdata(req_wdata[31:0]),
        .resp_valid(a_rv), .resp_rdata(a_rdata), .resp_err(a_err),
        .mem_read(a_mr), .mem_write(a_mw), .mem_addr(a_maddr),
        .mem_wdata(a_mwdata), .mem_byte_en(a_be),
        .mem_rdata(mem_rdata[31:0]), .mem_resp(mem_resp & ~cur_sel)
    );

    lsu_mem_ctrl #(.XLEN(64), .TIMEOUT_CYCLES(TO)) dut64 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid & cur_sel), .req_ready(b_ready),
        .req_write(req_write), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(b_rv), .resp_rdata(b_rdata), .resp_err(b_err),
        .mem_read(b_mr), .mem_write(b_mw), .mem_addr(b_maddr),
        .mem_wdata(b_mwdata), .mem_byte_en(b_be),
        .mem_rdata(mem_rdata), .mem_resp(mem_resp & cur_sel)
    );

    // Observation mux for the selected instance.
    always_comb begin
        if (cur_sel) begin
            o_ready = b_ready; o_rv = b_rv; o_mr = b_mr; o_mw = b_mw;
            o_rdata = b_rdata; o_maddr = b_maddr; o_mwdata = b_mwdata;
            o_err = b_err; o_be = b_be;
        end else begin
            o_ready = a_ready; o_rv = a_rv; o_mr = a_mr; o_mw = a_mw;
            o_rdata = {32'h0, a_rdata}; o_maddr = {32'h0, a_maddr};
            o_mwdata = {32'h0, a_mwdata}; o_err = a_err; o_be = {4'h0, a_be};
        end
    end

    typedef struct {
        bit          sel;
        bit          wr;
        logic [2:0]  f3;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] rdata;
        int          d;      // wait cycles before mem_resp; -1 = never
        logic [1:0]  err;
        logic [7:0]  be;
        logic [63:0] maddr;
        logic [63:0] mwdata;
        logic [63:0] rres;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: access semantics from size, alignment and lane arithmetic.
    task automatic model(input bit sel, input bit wr, input logic [2:0] f3,
                         input logic [63:0] addr_in, input logic [63:0] wdata,
                         input logic [63:0] rdata, output vec_t v);
        int          xl, nb, off;
        bit          illegal;
        logic [63:0] addr, val, lim;
        xl = sel ? 64 : 32;
        addr = sel ? addr_in : (addr_in & 64'hFFFF_FFFF);
        nb = 1 << f3[1:0];
        off = int'(addr % (xl / 8));
        illegal = (f3 == 3'd7) || (xl == 32 && (f3 == 3'd3 || f3 == 3'd6)) || (wr && f3 >= 3'd4);
        v.sel = sel; v.wr = wr; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
        v.be = 8'h0; v.maddr = 64'h0; v.mwdata = 64'h0; v.rres = 64'h0;
        if (illegal) v.err = 2'b10;
        else if ((addr % nb) != 0) v.err = 2'b01;
        else v.err = 2'b00;
        if (v.err == 2'b00) begin
            v.maddr = addr - off;
            v.be = 8'(((1 << nb) - 1) << off);
            if (wr) begin
                for (int j = 0; j < nb; j++) v.mwdata[8*(off+j) +: 8] = wdata[8*j +: 8];
            end else begin
                val = rdata >> (8 * off);
                if (nb < 8) begin
                    lim = 64'd1 << (8 * nb);
                    val = val & (lim - 64'd1);
                    if (!f3[2] && val >= (lim >> 1)) val = val - lim;
                end
                if (xl == 32) val = val & 64'hFFFF_FFFF;
                v.rres = val;
            end
        end
    endtask

    // One complete access: request, optional memory reply, response and idle checks.
    task automatic run_txn(input vec_t v, input string tag);
        int k, exp_k, nrd, nwr;
        bit done;
        cur_sel = v.sel;
        @(negedge clk);
        chk({tag, "/ready"}, 64'(o_ready), 64'd1);
        req_valid = 1'b1; req_write = v.wr; req_funct3 = v.f3;
        req_addr = v.addr; req_wdata = v.wdata;
        @(negedge clk);
        req_valid = 1'b0;
        if (v.err == 2'b01 || v.err == 2'b10) begin
            chk({tag, "/err_rv"}, 64'(o_rv), 64'd1);
            chk({tag, "/err_code"}, 64'(o_err), 64'(v.err));
            chk({tag, "/err_rdata"}, o_rdata, 64'h0);
            chk({tag, "/err_strobe"}, 64'({o_mr, o_mw}), 64'd0);
        end else begin
            exp_k = (v.d < 0) ? TO + 1 : v.d + 1;
            nrd = 0; nwr = 0; done = 1'b0;
            for (k = 0; k < 40 && !done; k++) begin
                nrd += int'(o_mr); nwr += int'(o_mw);
                if (o_rv) begin
                    chk({tag, "/latency"}, 64'(k), 64'(exp_k));
                    chk({tag, "/err"}, 64'(o_err), 64'(v.err));
                    chk({tag, "/rdata"}, o_rdata, v.rres);
                    mem_resp = 1'b0;
                    done = 1'b1;
                end else begin
                    chk({tag, "/maddr"}, o_maddr, v.maddr);
                    chk({tag, "/be"}, 64'(o_be), 64'(v.be));
                    if (v.wr) chk({tag, "/wdata"}, o_mwdata, v.mwdata);
                    mem_resp = (v.d >= 0 && k == v.d);
                    mem_rdata = v.rdata;
                    @(negedge clk);
                end
            end
            if (!done) chk({tag, "/resp_seen"}, 64'd0, 64'd1);
            chk({tag, "/nread"}, 64'(nrd), v.wr ? 64'd0 : 64'd1);
            chk({tag, "/nwrite"}, 64'(nwr), v.wr ? 64'd1 : 64'd0);
        end
        @(negedge clk);
        chk({tag, "/rv_drop"}, 64'(o_rv), 64'd0);
        chk({tag, "/idle_ready"}, 64'(o_ready), 64'd1);
        chk({tag, "/idle_out"}, o_maddr | o_rdata | 64'(o_be), 64'h0);
    endtask

    vec_t tbl [21];
    vec_t rv;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        //        sel  wr   f3      addr      wdata                   rdata                   d   err    be     maddr   mwdata                  rres
        tbl[0]  = '{1'b0, 1'b0, 3'b000, 64'h103, 64'h0,               64'h80AA_BBCC,          0, 2'b00, 8'h08, 64'h100, 64'h0,               64'hFFFF_FF80};
        tbl[1]  = '{1'b0, 1'b0, 3'b101, 64'h202, 64'h0,               64'h9123_4567,          3, 2'b00, 8'h0C, 64'h200, 64'h0,               64'h0000_9123};
        tbl[2]  = '{1'b0, 1'b1, 3'b000, 64'h7,   64'h1234_56AB,       64'h0,                  0, 2'b00, 8'h08, 64'h4,   64'hAB00_0000,       64'h0};
        tbl[3]  = '{1'b0, 1'b0, 3'b010, 64'h102, 64'h0,               64'h0,                  0, 2'b01, 8'h00, 64'h0,   64'h0,               64'h0};
        tbl[4]  = '{1'b0, 1'b1, 3'b100, 64'h0,   64'h55,              64'h0,                  0, 2'b10, 8'h00, 64'h0,   64'h0,               64'h0};
        tbl[5]  = '{1'b0, 1'b0, 3'b011, 64'h0,   64'h0,               64'h0,                  0, 2'b10, 8'h00, 64'h0,   64'h0,               64'h0};
        tbl[6]  = '{1'b0, 1'b0, 3'b010, 64'h104, 64'h0,               64'hDEAD_BEEF,          1, 2'b00, 8'h0F, 64'h104, 64'h0,               64'hDEAD_BEEF};
        tbl[7]  = '{1'b0, 1'b0, 3'b001, 64'h10,  64'h0,               64'h0000_8001,          0, 2'b00, 8'h03, 64'h10,  64'h0,               64'hFFFF_8001};
        tbl[8]  = '{1'b0, 1'b1, 3'b001, 64'h2,   64'hAAAA_5678,       64'h0,                  2, 2'b00, 8'h0C, 64'h0,   64'h5678_0000,       64'h0};
        tbl[9]  = '{1'b0, 1'b0, 3'b110, 64'h0,   64'h0,               64'h0,                  0, 2'b10, 8'h00, 64'h0,   64'h0,               64'h0};
        tbl[10] = '{1'b0, 1'b1, 3'b010, 64'h8,   64'h1122_3344,       64'h0,                  4, 2'b00, 8'h0F, 64'h8,   64'h1122_3344,       64'h0};
        tbl[11] = '{1'b0, 1'b1, 3'b001, 64'h1,   64'h0,               64'h0,                  0, 2'b01, 8'h00, 64'h0,   64'h0,               64'h0};
        tbl[12] = '{1'b1, 1'b0, 3'b011, 64'h8,   64'h0,  64'h8000_0000_0000_0001,             2, 2'b00, 8'hFF, 64'h8,   64'h0,  64'h8000_0000_0000_0001};
        tbl[13] = '{1'b1, 1'b0, 3'b110, 64'h4,   64'h0,  64'h8765_4321_0000_0000,             0, 2'b00, 8'hF0, 64'h0,   64'h0,  64'h0000_0000_8765_4321};
        tbl[14] = '{1'b1, 1'b0, 3'b010, 64'h4,   64'h0,  64'h8765_4321_0000_0000,             1, 2'b00, 8'hF0, 64'h0,   64'h0,  64'hFFFF_FFFF_8765_4321};
        tbl[15] = '{1'b1, 1'b0, 3'b111, 64'h0,   64'h0,               64'h0,                  0, 2'b10, 8'h00, 64'h0,   64'h0,               64'h0};
        tbl[16] = '{1'b1, 1'b1, 3'b011, 64'h10,  64'h0123_4567_89AB_CDEF, 64'h0,              0, 2'b00, 8'hFF, 64'h10,  64'h0123_4567_89AB_CDEF, 64'h0};
        tbl[17] = '{1'b1, 1'b0, 3'b011, 64'h4,   64'h0,               64'h0,                  0, 2'b01, 8'h00, 64'h0,   64'h0,               64'h0};
        tbl[18] = '{1'b1, 1'b0, 3'b100, 64'h1D,  64'h0,  64'h0000_F500_0000_0000,             1, 2'b00, 8'h20, 64'h18,  64'h0,  64'h0000_0000_0000_00F5};
        tbl[19] = '{1'b1, 1'b0, 3'b000, 64'h1D,  64'h0,  64'h0000_F500_0000_0000,             0, 2'b00, 8'h20, 64'h18,  64'h0,  64'hFFFF_FFFF_FFFF_FFF5};
        tbl[20] = '{1'b1, 1'b1, 3'b000, 64'h21,  64'hFFFF_FFFF_FFFF_FF5A, 64'h0,              3, 2'b00, 8'h02, 64'h20,  64'h0000_0000_0000_5A00, 64'h0};

        // Reset state of both instances.
        repeat (2) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            cur_sel = s[0];
            #1;
            chk("reset/ready", 64'(o_ready), 64'd1);
            chk("reset/outs", 64'({o_rv, o_mr, o_mw, o_err}) | o_maddr | o_rdata | o_mwdata | 64'(o_be), 64'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 21; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

        // Timeout, then a stray late reply that must be ignored.
        rv = '{1'b0, 1'b0, 3'b010, 64'h20, 64'h0, 64'h0, -1, 2'b11, 8'h0F, 64'h20, 64'h0, 64'h0};
        run_txn(rv, "timeout");
        @(negedge clk);
        mem_resp = 1'b1; mem_rdata = 64'hFFFF_FFFF;
        @(negedge clk);
        mem_resp = 1'b0;
        chk("late/rv", 64'(o_rv), 64'd0);
        chk("late/ready", 64'(o_ready), 64'd1);
        @(negedge clk);
        chk("late/rv2", 64'(o_rv), 64'd0);
        run_txn(tbl[6], "after_timeout");

        // Asynchronous reset in ISSUE (phase 0) and WAIT (phase 1).
        for (int ph = 0; ph < 2; ph++) begin
            cur_sel = 1'b1;
            @(negedge clk);
            req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b011;
            req_addr = 64'h40; req_wdata = 64'h0;
            @(negedge clk);
            req_valid = 1'b0;
            if (ph == 1) @(negedge clk);
            chk("rst/pre_addr", o_maddr, 64'h40);
            chk("rst/pre_read", 64'(o_mr), (ph == 0) ? 64'd1 : 64'd0);
            #2 rst_n = 1'b0;
            #1;
            chk("rst/outs", 64'({o_rv, o_mr, o_mw, o_err}) | o_maddr | o_mwdata | o_rdata | 64'(o_be), 64'h0);
            chk("rst/ready", 64'(o_ready), 64'd1);
            @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);
            chk("rst/no_resp", 64'(o_rv), 64'd0);
        end
        run_txn(tbl[12], "post_reset_ld");

        // Randomized accesses against the reference model.
        for (int i = 0; i < 60; i++) begin
            logic [63:0] a, w, r;
            bit s;
            s = 1'($urandom_range(0, 1));
            a = {32'($urandom), 32'($urandom)};
            w = {32'($urandom), 32'($urandom)};
            r = {32'($urandom), 32'($urandom)};
            model(s, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, w, r, rv);
            rv.d = $urandom_range(0, 4);
            run_txn(rv, $sformatf("rnd%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
